nnrv_ram_arb: RTL and testbench

- Shares the single-port data/instruction RAM between instruction fetch (read-only) and the load/store stream issued by the exec stage.
- Arbitrates per cycle, registers the RAM command, and routes the 1-cycle-latency read data back to the requester that owns it.
- Data wins on conflict; a streak counter bounds fetch starvation.
- Branch flush discards an in-flight fetch response.

---
 rtl/nnrv_ram_arb_pkg.sv | 21 ++
 rtl/nnrv_ram_arb_if.sv | 53 +++++
 rtl/nnrv_arb_streak.sv | 51 +++++
 rtl/nnrv_ram_arb.sv | 117 +++++++++++
 tb/tb_nnrv_ram_arb.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nnrv_ram_arb_pkg.sv
// nnrv_pkg: shared types for the RAM arbiter.
// Holds the owner encoding used to route read data back to a requester and
// the tag record that travels alongside each read through the pipeline.
package nnrv_pkg;

    // Which requester issued a read.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    // One tag per issued RAM command: vld is set only for reads that still
    // owe a response; own selects the response port.
    typedef struct packed {
        logic   vld;
        owner_e own;
    } tag_t;

    localparam tag_t TAG_NONE = '{vld: 1'b0, own: OWN_IF};

endpackage

// File: rtl/nnrv_ram_arb_if.sv
// nnrv_ram_arb_if: bundle of every arbiter signal except clock and reset.
// Signal names keep their i_/o_ prefixes relative to the arbiter.
//   fetch side : i_if_req, i_if_addr, o_if_gnt, o_if_valid, o_if_data, i_flush
//   data side  : i_dm_rd_en, i_dm_wr_en, i_dm_addr, i_dm_data, i_dm_mask,
//                o_dm_gnt, o_dm_valid, o_dm_data
//   RAM side   : o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata, o_ram_be,
//                i_ram_rdata
// Modport slave is taken by the arbiter, master by whoever surrounds it.
interface nnrv_ram_arb_if #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  i_if_req;
    logic [XLEN-1:0]       i_if_addr;
    logic                  o_if_gnt;
    logic                  o_if_valid;
    logic [XLEN-1:0]       o_if_data;
    logic                  i_flush;

    logic                  i_dm_rd_en;
    logic                  i_dm_wr_en;
    logic [XLEN-1:0]       i_dm_addr;
    logic [XLEN-1:0]       i_dm_data;
    logic [3:0]            i_dm_mask;
    logic                  o_dm_gnt;
    logic                  o_dm_valid;
    logic [XLEN-1:0]       o_dm_data;

    logic                  o_ram_en;
    logic                  o_ram_we;
    logic [ADDR_WIDTH-1:0] o_ram_addr;
    logic [XLEN-1:0]       o_ram_wdata;
    logic [3:0]            o_ram_be;
    logic [XLEN-1:0]       i_ram_rdata;

    modport slave (
        input  i_if_req, i_if_addr, i_flush,
        input  i_dm_rd_en, i_dm_wr_en, i_dm_addr, i_dm_data, i_dm_mask,
        input  i_ram_rdata,
        output o_if_gnt, o_if_valid, o_if_data,
        output o_dm_gnt, o_dm_valid, o_dm_data,
        output o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata, o_ram_be
    );

    modport master (
        output i_if_req, i_if_addr, i_flush,
        output i_dm_rd_en, i_dm_wr_en, i_dm_addr, i_dm_data, i_dm_mask,
        output i_ram_rdata,
        input  o_if_gnt, o_if_valid, o_if_data,
        input  o_dm_gnt, o_dm_valid, o_dm_data,
        input  o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata, o_ram_be
    );
endinterface

// File: rtl/nnrv_arb_streak.sv
// nnrv_arb_streak: per-cycle priority decision between fetch and data.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   if_req    : fetch request pending
//   dm_req    : data (load or store) request pending
//   gnt_if    : fetch granted this cycle (combinational)
//   gnt_dm    : data granted this cycle (combinational)
// Data normally wins; after MAX_DATA_STREAK data grants in a row with fetch
// waiting, fetch gets one slot so it cannot starve.
module nnrv_arb_streak #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic dm_req,
    output logic gnt_if,
    output logic gnt_dm
);

    localparam logic [3:0] LIMIT = 4'(MAX_DATA_STREAK);

    logic [3:0] streak;

    // Grants are suppressed during reset so nothing is issued from a
    // half-cleared pipeline.
    always_comb begin
        gnt_if = 1'b0;
        gnt_dm = 1'b0;
        if (!rst) begin
            if (dm_req && !(if_req && (streak == LIMIT))) begin
                gnt_dm = 1'b1;
            end else if (if_req) begin
                gnt_if = 1'b1;
            end
        end
    end

    // Counts data wins only while fetch is actually waiting; saturates so a
    // fetch that drops its request is never penalised later.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= 4'd0;
        end else if (!if_req || gnt_if) begin
            streak <= 4'd0;
        end else if (gnt_dm && (streak != LIMIT)) begin
            streak <= streak + 4'd1;
        end
    end

endmodule

// File: rtl/nnrv_ram_arb.sv
// nnrv_ram_arb: shares one single-port RAM between instruction fetch and the
// load/store stream.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : nnrv_ram_arb_if.slave carrying fetch, data and RAM signals
// A grant in cycle N registers the RAM command for cycle N+1; the RAM answers
// in N+2, where the response is steered to its owner by a two-stage tag
// pipeline. Flush kills fetch tags still in the pipeline.
module nnrv_ram_arb
    import nnrv_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int ADDR_WIDTH      = 8,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    nnrv_ram_arb_if.slave  bus
);

    logic            dm_req;
    logic            dm_store;
    logic            gnt_if;
    logic            gnt_dm;
    logic            if_hit;
    logic            dm_hit;
    tag_t            tag_cmd;
    tag_t            tag_rsp;
    logic [XLEN-1:0] if_data_q;
    logic [XLEN-1:0] dm_data_q;
    logic            unused_addr_bits;

    // rd and wr together count as a store.
    assign dm_req   = bus.i_dm_rd_en | bus.i_dm_wr_en;
    assign dm_store = bus.i_dm_wr_en;

    nnrv_arb_streak #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_streak (
        .clk    (i_clk),
        .rst    (i_rst),
        .if_req (bus.i_if_req),
        .dm_req (dm_req),
        .gnt_if (gnt_if),
        .gnt_dm (gnt_dm)
    );

    assign bus.o_if_gnt = gnt_if;
    assign bus.o_dm_gnt = gnt_dm;

    // Byte offset and bits above the RAM range are not part of the word address.
    assign unused_addr_bits = ^{bus.i_if_addr[XLEN-1:ADDR_WIDTH+2], bus.i_if_addr[1:0],
                                bus.i_dm_addr[XLEN-1:ADDR_WIDTH+2], bus.i_dm_addr[1:0]};

    // RAM command register. Without a grant only en/we drop; address, data
    // and byte enables keep their last value to avoid needless toggling.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_ram_en    <= 1'b0;
            bus.o_ram_we    <= 1'b0;
            bus.o_ram_addr  <= '0;
            bus.o_ram_wdata <= '0;
            bus.o_ram_be    <= 4'h0;
        end else begin
            bus.o_ram_en <= gnt_if | gnt_dm;
            bus.o_ram_we <= gnt_dm & dm_store;
            if (gnt_dm) begin
                bus.o_ram_addr  <= bus.i_dm_addr[ADDR_WIDTH+1:2];
                bus.o_ram_be    <= bus.i_dm_mask;
                bus.o_ram_wdata <= bus.i_dm_data;
            end else if (gnt_if) begin
                bus.o_ram_addr  <= bus.i_if_addr[ADDR_WIDTH+1:2];
                bus.o_ram_be    <= 4'hF;
            end
        end
    end

    // tag_cmd travels with the command cycle, tag_rsp with the data-return
    // cycle. A flush kills a fetch both at grant time and while in tag_cmd;
    // one already in tag_rsp is being returned and is left alone.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tag_cmd <= TAG_NONE;
            tag_rsp <= TAG_NONE;
        end else begin
            tag_cmd.vld <= (gnt_if & ~bus.i_flush) | (gnt_dm & ~dm_store);
            tag_cmd.own <= gnt_dm ? OWN_DM : OWN_IF;
            tag_rsp.vld <= tag_cmd.vld & ~(bus.i_flush & (tag_cmd.own == OWN_IF));
            tag_rsp.own <= tag_cmd.own;
        end
    end

    assign if_hit = tag_rsp.vld && (tag_rsp.own == OWN_IF);
    assign dm_hit = tag_rsp.vld && (tag_rsp.own == OWN_DM);

    // The RAM word arrives in the response cycle itself, so it is passed
    // straight out and captured for holding while valid is low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            if_data_q <= '0;
            dm_data_q <= '0;
        end else begin
            if (if_hit) begin
                if_data_q <= bus.i_ram_rdata;
            end
            if (dm_hit) begin
                dm_data_q <= bus.i_ram_rdata;
            end
        end
    end

    assign bus.o_if_valid = if_hit;
    assign bus.o_dm_valid = dm_hit;
    assign bus.o_if_data  = if_hit ? bus.i_ram_rdata : if_data_q;
    assign bus.o_dm_data  = dm_hit ? bus.i_ram_rdata : dm_data_q;

endmodule

// File: tb/tb_nnrv_ram_arb.sv
// tb_nnrv_ram_arb: self-checking bench for nnrv_ram_arb.
// A synchronous RAM model answers the DUT's commands; an independent
// reference tracks expected grants, command fields and responses from a
// shadow memory updated in grant order.
module tb_nnrv_ram_arb;

    localparam int XLEN = 32;
    localparam int AW   = 8;
    localparam int MAXS = 4;

    typedef struct {
        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        flush;
        logic        rd;
        logic        wr;
        logic [31:0] dm_addr;
        logic [31:0] dm_data;
        logic [3:0]  mask;
        logic        chk_gnt;
        logic        exp_if_gnt;
        logic        exp_dm_gnt;
    } vec_t;

    typedef struct {
        int          due;
        logic        own;
        logic [31:0] data;
        logic        live;
    } resp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nnrv_ram_arb_if #(.XLEN(XLEN), .ADDR_WIDTH(AW)) bus();

    nnrv_ram_arb #(
        .XLEN(XLEN), .ADDR_WIDTH(AW), .MAX_DATA_STREAK(MAXS)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hDEADBEEF;
        return 32'h5A000000 ^ (32'(i) * 32'h00010203);
    endfunction

    // Synchronous RAM: write-before-read across cycles, read data the cycle
    // after the command.
    logic [31:0] ram_mem [0:255];
    logic        ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else if (bus.o_ram_en) begin
            if (bus.o_ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.o_ram_be[b]) ram_mem[bus.o_ram_addr][8*b +: 8] <= bus.o_ram_wdata[8*b +: 8];
            end else begin
                bus.i_ram_rdata <= ram_mem[bus.o_ram_addr];
            end
        end
    end

    // Reference state
    logic [31:0] shadow [0:255];
    resp_t       pend [$];
    int          streak;
    int          cyc;
    logic        e_en, e_we;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic [31:0] hold_if, hold_dm;
    logic        m_if_gnt, m_dm_gnt;
    logic        e_ifv, e_dmv;
    logic [31:0] e_ifd, e_dmd;

    // Last sampled outputs for hand-written sequences
    logic        s_if_gnt, s_dm_gnt, s_if_valid, s_dm_valid, s_ram_we;
    logic [31:0] s_if_data, s_dm_data;
    logic [7:0]  s_ram_addr;
    logic [3:0]  s_ram_be;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(logic r, logic ifr, logic [31:0] ifa, logic fl,
                                logic rd, logic wr, logic [31:0] da, logic [31:0] dd,
                                logic [3:0] mk_mask, logic cg, logic eig, logic edg);
        vec_t v;
        v.rst = r; v.if_req = ifr; v.if_addr = ifa; v.flush = fl;
        v.rd = rd; v.wr = wr; v.dm_addr = da; v.dm_data = dd; v.mask = mk_mask;
        v.chk_gnt = cg; v.exp_if_gnt = eig; v.exp_dm_gnt = edg;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    endfunction

    task automatic checkOutput(input vec_t v);
        logic dreq;
        dreq = v.rd | v.wr;
        m_if_gnt = 1'b0;
        m_dm_gnt = 1'b0;
        if (!v.rst) begin
            if (dreq && v.if_req) begin
                if (streak == MAXS) m_if_gnt = 1'b1;
                else m_dm_gnt = 1'b1;
            end else if (dreq) m_dm_gnt = 1'b1;
            else if (v.if_req) m_if_gnt = 1'b1;
        end
        e_ifv = 1'b0; e_ifd = hold_if;
        e_dmv = 1'b0; e_dmd = hold_dm;
        foreach (pend[i]) begin
            if (pend[i].due == cyc && pend[i].live) begin
                if (pend[i].own == 1'b0) begin e_ifv = 1'b1; e_ifd = pend[i].data; end
                else begin e_dmv = 1'b1; e_dmd = pend[i].data; end
            end
        end
        check("if_gnt", bus.o_if_gnt, m_if_gnt);
        check("dm_gnt", bus.o_dm_gnt, m_dm_gnt);
        if (v.chk_gnt) begin
            check("table_if_gnt", bus.o_if_gnt, v.exp_if_gnt);
            check("table_dm_gnt", bus.o_dm_gnt, v.exp_dm_gnt);
        end
        check("ram_en", bus.o_ram_en, e_en);
        check("ram_we", bus.o_ram_we, e_we);
        check("ram_addr", bus.o_ram_addr, e_addr);
        check("ram_be", bus.o_ram_be, e_be);
        check("ram_wdata", bus.o_ram_wdata, e_wdata);
        check("if_valid", bus.o_if_valid, e_ifv);
        check("if_data", bus.o_if_data, e_ifd);
        check("dm_valid", bus.o_dm_valid, e_dmv);
        check("dm_data", bus.o_dm_data, e_dmd);
    endtask

    task automatic updateModel(input vec_t v);
        resp_t keep [$];
        int    w;
        if (v.rst) begin
            e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_be = 0;
            streak = 0; pend.delete(); hold_if = 0; hold_dm = 0;
            return;
        end
        if (e_ifv) hold_if = e_ifd;
        if (e_dmv) hold_dm = e_dmd;
        e_en = m_if_gnt | m_dm_gnt;
        e_we = m_dm_gnt & v.wr;
        if (m_dm_gnt) begin
            e_addr = v.dm_addr[AW+1:2]; e_be = v.mask; e_wdata = v.dm_data;
        end else if (m_if_gnt) begin
            e_addr = v.if_addr[AW+1:2]; e_be = 4'hF;
        end
        foreach (pend[i]) begin
            if (pend[i].due > cyc) begin
                if (v.flush && pend[i].own == 1'b0) pend[i].live = 1'b0;
                keep.push_back(pend[i]);
            end
        end
        pend = keep;
        if (m_if_gnt) begin
            w = int'(v.if_addr[AW+1:2]);
            pend.push_back('{due: cyc + 2, own: 1'b0, data: shadow[w], live: !v.flush});
        end
        if (m_dm_gnt) begin
            w = int'(v.dm_addr[AW+1:2]);
            if (v.wr) begin
                for (int b = 0; b < 4; b++)
                    if (v.mask[b]) shadow[w][8*b +: 8] = v.dm_data[8*b +: 8];
            end else begin
                pend.push_back('{due: cyc + 2, own: 1'b1, data: shadow[w], live: 1'b1});
            end
        end
        if (!v.if_req || m_if_gnt) streak = 0;
        else if (m_dm_gnt && streak < MAXS) streak++;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst            = v.rst;
        bus.i_if_req   = v.if_req;
        bus.i_if_addr  = v.if_addr;
        bus.i_flush    = v.flush;
        bus.i_dm_rd_en = v.rd;
        bus.i_dm_wr_en = v.wr;
        bus.i_dm_addr  = v.dm_addr;
        bus.i_dm_data  = v.dm_data;
        bus.i_dm_mask  = v.mask;
        #1;
        checkOutput(v);
        s_if_gnt = bus.o_if_gnt; s_dm_gnt = bus.o_dm_gnt;
        s_if_valid = bus.o_if_valid; s_dm_valid = bus.o_dm_valid;
        s_if_data = bus.o_if_data; s_dm_data = bus.o_dm_data;
        s_ram_we = bus.o_ram_we; s_ram_addr = bus.o_ram_addr; s_ram_be = bus.o_ram_be;
        updateModel(v);
        cyc++;
    endtask

    vec_t table_v [$];
    vec_t rv;
    int   cnt;

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        rst = 1'b1;
        bus.i_if_req = 0; bus.i_if_addr = 0; bus.i_flush = 0;
        bus.i_dm_rd_en = 0; bus.i_dm_wr_en = 0; bus.i_dm_addr = 0;
        bus.i_dm_data = 0; bus.i_dm_mask = 0;
        streak = 0; cyc = 0;
        e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_be = 0;
        hold_if = 0; hold_dm = 0;
        repeat (3) @(posedge clk);

        // Directed fetch of word 4
        applyStimulus(mk(0, 1, 32'h10, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        applyStimulus(idle());
        check("fetch_cmd_addr", s_ram_addr, 8'd4);
        check("fetch_cmd_be", s_ram_be, 4'hF);
        applyStimulus(idle());
        check("fetch_valid", s_if_valid, 1'b1);
        check("fetch_data", s_if_data, 32'hDEADBEEF);

        // Store then load the same word
        applyStimulus(mk(0, 0, 0, 0, 0, 1, 32'h20, 32'h000000AB, 4'b0001, 1, 0, 1));
        applyStimulus(mk(0, 0, 0, 0, 1, 0, 32'h20, 0, 4'hF, 1, 0, 1));
        check("store_we", s_ram_we, 1'b1);
        check("store_be", s_ram_be, 4'b0001);
        check("store_addr", s_ram_addr, 8'd8);
        applyStimulus(idle());
        applyStimulus(idle());
        check("load_valid", s_dm_valid, 1'b1);
        check("load_low_byte", s_dm_data & 32'hFF, 32'hAB);

        // Flush kills the fetch granted one cycle earlier, not the load
        applyStimulus(mk(0, 1, 32'h14, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        applyStimulus(mk(0, 0, 0, 1, 1, 0, 32'h30, 0, 4'h3, 1, 0, 1));
        applyStimulus(idle());
        check("flush_if_valid", s_if_valid, 1'b0);
        applyStimulus(idle());
        check("flush_dm_valid", s_dm_valid, 1'b1);

        // Table of corner vectors
        for (int i = 0; i < 3; i++)
            table_v.push_back(mk(1, 1, 32'h18, 0, 1, 0, 32'h24, 0, 4'hF, 1, 0, 0));
        for (int i = 0; i < 3; i++) table_v.push_back(idle());
        table_v.push_back(mk(0, 0, 0, 0, 1, 1, 32'h40, 32'h12345678, 4'hF, 1, 0, 1));
        table_v.push_back(mk(0, 0, 0, 0, 1, 0, 32'h40, 0, 4'hF, 1, 0, 1));
        table_v.push_back(mk(0, 0, 0, 0, 0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, 1, 0, 1));
        table_v.push_back(mk(0, 1, 32'h13, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        table_v.push_back(mk(0, 1, 32'h13, 1, 0, 0, 0, 0, 0, 1, 1, 0));
        table_v.push_back(mk(0, 1, 32'hFFFFFF10, 0, 1, 0, 32'h44, 0, 4'hC, 1, 0, 1));
        table_v.push_back(mk(0, 1, 32'hFFFFFF10, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        table_v.push_back(idle());
        table_v.push_back(idle());
        foreach (table_v[i]) applyStimulus(table_v[i]);

        // Starvation: both held 12 cycles, fetch wins every fifth
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(mk(0, 1, 32'h8, 0, 1, 0, 32'(i * 4), 0, 4'hF, 1,
                             (i % 5) == 4, (i % 5) != 4));
            if (s_if_gnt) cnt++;
        end
        check("starve_if_grants", cnt, 2);
        applyStimulus(idle());
        applyStimulus(idle());

        // Back-to-back alternating fetch / load
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8 && (i % 2) == 0) applyStimulus(mk(0, 1, 32'(i * 4), 0, 0, 0, 0, 0, 0, 1, 1, 0));
            else if (i < 8) applyStimulus(mk(0, 0, 0, 0, 1, 0, 32'(64 + i * 4), 0, 4'hF, 1, 0, 1));
            else applyStimulus(idle());
            if (s_if_valid || s_dm_valid) cnt++;
        end
        check("b2b_responses", cnt, 8);

        // Reset in the middle of outstanding reads
        applyStimulus(mk(0, 1, 32'h4, 0, 1, 0, 32'h8, 0, 4'hF, 1, 0, 1));
        applyStimulus(mk(0, 1, 32'h4, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        applyStimulus(mk(1, 1, 32'h4, 0, 1, 0, 32'h8, 0, 4'hF, 1, 0, 0));
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(idle());
            if (s_if_valid || s_dm_valid) cnt++;
        end
        check("reset_drops_valids", cnt, 0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            rv.rst     = ($urandom_range(0, 63) == 0);
            rv.if_req  = ($urandom_range(0, 3) != 0);
            rv.if_addr = ($urandom & 32'hFFFFFC03) | (32'($urandom_range(0, 15)) << 2);
            rv.flush   = ($urandom_range(0, 9) == 0);
            rv.rd      = $urandom_range(0, 1);
            rv.wr      = ($urandom_range(0, 2) == 0);
            rv.dm_addr = ($urandom & 32'hFFFFFC03) | (32'($urandom_range(0, 15)) << 2);
            rv.dm_data = $urandom;
            rv.mask    = 4'($urandom);
            rv.chk_gnt = 1'b0;
            rv.exp_if_gnt = 1'b0;
            rv.exp_dm_gnt = 1'b0;
            applyStimulus(rv);
        end
        applyStimulus(idle());
        applyStimulus(idle());
        applyStimulus(idle());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
